if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current `pc`/`ce`, fetches the instruction over a request/response instruction-memory bus (`addr_ok`/`data_ok` handshake), and drives the IF/ID pipeline outputs to decode.
- Raises a stall request while an instruction is outstanding, so the PC and IF/ID registers freeze.
- Discards in-flight fetches on a pipeline flush.

Parameters:
- ADDR_W, 32, width of PC and instruction address.
- INST_W, 32, instruction width.
- NOP_INST, 32'h00000000, value driven on `id_inst` for a bubble.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  6  pipeline stall vector; bit0 = PC, bit1 = IF/ID, bit2 = ID/EX; 1 = stop.
- flush  in  1  pipeline flush (exception/eret); cancels the current fetch.
- pc_i  in  ADDR_W  current PC from the PC register.
- ce_i  in  1  fetch enable from the PC register.
- inst_req  out  1  request valid to instruction memory.
- inst_addr  out  ADDR_W  request address; registered; stable while inst_req=1.
- inst_addr_ok  in  1  memory accepts the request this cycle.
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  INST_W  read data.
- stallreq_o  out  1  combinational stall request to the stall controller.
- id_pc  out  ADDR_W  IF/ID register: PC of the instruction.
- id_inst  out  INST_W  IF/ID register: instruction.

Behaviour:
- Reset: rst=1 at a rising edge gives state=IDLE, inst_req=0, inst_addr=0, id_pc=0, id_inst=NOP_INST, buffer cleared. stallreq_o=0 while rst=1. Reset mid-transaction abandons it; the memory must also be in reset.
- Bus rules:
  - At most one outstanding request.
  - inst_req stays high until inst_addr_ok; it is never withdrawn.
  - inst_data_ok never arrives in the same cycle as its inst_addr_ok, and never arrives in IDLE or REQ.
- FSM states: IDLE, REQ, RESP, DONE, DISCARD.
- IDLE:
  - If ce_i=1 and flush=0: latch inst_addr<=pc_i, inst_req<=1, go to REQ.
  - stallreq_o=ce_i.
- REQ:
  - On inst_addr_ok: inst_req<=0. Go to RESP, or to DISCARD if flush was seen in this or any earlier REQ cycle (sticky flag).
  - stallreq_o=1.
- RESP:
  - On inst_data_ok with flush=0: buffer<=inst_rdata, buffer PC<=inst_addr, go to DONE.
  - flush=1 (with or without data_ok): a simultaneous data_ok is dropped and the next state is IDLE; flush=1 without data_ok goes to DISCARD.
  - stallreq_o=1.
- DISCARD:
  - Wait for inst_data_ok, drop the data, go to IDLE.
  - stallreq_o=1.
- DONE:
  - stallreq_o=0.
  - flush=1: go to IDLE, buffer discarded.
  - Else if stall[1]=0: id_pc<=buffer PC, id_inst<=buffer, go to IDLE. The PC advances in the same cycle.
  - Else hold.
- IF/ID output update, each cycle, in priority order:
  1. flush=1: id_pc<=0, id_inst<=NOP_INST.
  2. stall[1]=1 and stall[2]=0: bubble, id_pc<=0, id_inst<=NOP_INST.
  3. stall[1]=1 and stall[2]=1: hold.
  4. stall[1]=0 in DONE: load the buffer.
  5. stall[1]=0 outside DONE: bubble. This cannot occur when the controller honours stallreq_o.
- Latency: with addr_ok and data_ok each one cycle after their trigger, id_inst updates at the 4th rising edge after IDLE with ce_i=1. Minimum 4 cycles per instruction; throughput is not pipelined.
- Address width: inst_addr is taken verbatim from pc_i; no alignment check.

Test Plan:
- Zero-wait fetch: ce_i=1, pc_i=32'h0, addr_ok 1 cycle after req, data_ok 1 cycle later with rdata=32'h3C010001, stall driven by stallreq_o -> inst_req high 1 cycle with inst_addr=0; id_pc=0, id_inst=32'h3C010001 at edge 4; stallreq_o low only in DONE.
- Backpressure: hold addr_ok low 3 cycles, then data_ok 2 cycles later -> inst_req/inst_addr stable for all 4 REQ cycles, stallreq_o=1 throughout, id outputs bubble (0/NOP) until delivery.
- Downstream stall in DONE: stall=6'b000111 for 2 cycles -> id outputs held, state stays DONE; releasing stall loads the buffer in the next cycle.
- Flush in RESP: flush pulse while waiting, data_ok arrives 2 cycles later with 32'hDEADBEEF -> value never appears on id_inst; id_inst=NOP; the next fetch uses the new pc_i.
- Flush in REQ before addr_ok: inst_req stays high until addr_ok, then the response is discarded -> DISCARD then IDLE; no id update.
- Reset mid-RESP: rst=1 for 1 cycle -> state IDLE, inst_req=0, id_pc=0, id_inst=NOP, stallreq_o=0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues one request at a time to instruction memory,
// buffers the returned word, and hands it to the IF/ID register when decode is
// ready. While a fetch is outstanding it asks the stall controller to freeze the
// PC and IF/ID registers. A flush cancels the fetch, and a response that is
// still in flight is drained and discarded.
module if_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [INST_W-1:0] inst_rdata,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RESP    = 3'd2,
    S_DONE    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                inst_req_q, inst_req_d;
  logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
  logic                flush_seen_q, flush_seen_d;
  logic [INST_W-1:0]   buf_inst_q, buf_inst_d;
  logic [ADDR_W-1:0]   buf_pc_q, buf_pc_d;
  logic [ADDR_W-1:0]   id_pc_q, id_pc_d;
  logic [INST_W-1:0]   id_inst_q, id_inst_d;
  logic                stallreq_raw;

  // Only the IF/ID and ID/EX stall bits matter to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  // Next-state and bus control: one outstanding request, never withdrawn.
  always_comb begin
    state_d      = state_q;
    inst_req_d   = inst_req_q;
    inst_addr_d  = inst_addr_q;
    flush_seen_d = flush_seen_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    stallreq_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        stallreq_raw = ce_i;
        if (ce_i && !flush) begin
          inst_addr_d  = pc_i;
          inst_req_d   = 1'b1;
          flush_seen_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        stallreq_raw = 1'b1;
        // A flush while the request is pending cannot retract it; remember it
        // so the eventual response is dropped.
        flush_seen_d = flush_seen_q | flush;
        if (inst_addr_ok) begin
          inst_req_d = 1'b0;
          state_d    = (flush_seen_q || flush) ? S_DISCARD : S_RESP;
        end
      end
      S_RESP: begin
        stallreq_raw = 1'b1;
        if (flush) begin
          state_d = inst_data_ok ? S_IDLE : S_DISCARD;
        end else if (inst_data_ok) begin
          buf_inst_d = inst_rdata;
          buf_pc_d   = inst_addr_q;
          state_d    = S_DONE;
        end
      end
      S_DISCARD: begin
        stallreq_raw = 1'b1;
        if (inst_data_ok) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        stallreq_raw = 1'b0;
        if (flush || !stall[1]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        inst_req_d = 1'b0;
      end
    endcase
  end

  // IF/ID register next value: flush, then bubble, then hold, then load.
  always_comb begin
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    if (flush) begin
      id_pc_d   = '0;
      id_inst_d = NOP_INST;
    end else if (stall[1] && !stall[2]) begin
      id_pc_d   = '0;
      id_inst_d = NOP_INST;
    end else if (stall[1] && stall[2]) begin
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;
    end else if (state_q == S_DONE) begin
      id_pc_d   = buf_pc_q;
      id_inst_d = buf_inst_q;
    end else begin
      id_pc_d   = '0;
      id_inst_d = NOP_INST;
    end
  end

  // Fetch FSM, bus request and response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      inst_req_q   <= 1'b0;
      inst_addr_q  <= '0;
      flush_seen_q <= 1'b0;
      buf_inst_q   <= NOP_INST;
      buf_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      inst_req_q   <= inst_req_d;
      inst_addr_q  <= inst_addr_d;
      flush_seen_q <= flush_seen_d;
      buf_inst_q   <= buf_inst_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
    end else begin
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
    end
  end

  assign stallreq_o = rst ? 1'b0 : stallreq_raw;
  assign inst_req   = inst_req_q;
  assign inst_addr  = inst_addr_q;
  assign id_pc      = id_pc_q;
  assign id_inst    = id_inst_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized bench for the instruction-fetch stage. A small
// reference keeps the expected IF/ID contents at transaction level: what
// decode should see after each cycle given flush, stall and whether a
// fetched word is being handed over.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        stallreq_o;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  // Stall controller: honour the fetch stall request unless a test overrides it.
  logic       ovr_en;
  logic [5:0] ovr_val;
  assign stall = ovr_en ? ovr_val : (stallreq_o ? 6'b000011 : 6'b000000);

  if_fetch_unit #(
    .ADDR_W  (32),
    .INST_W  (32),
    .NOP_INST(NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .pc_i        (pc_i),
    .ce_i        (ce_i),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .stallreq_o  (stallreq_o),
    .id_pc       (id_pc),
    .id_inst     (id_inst)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: what decode should currently be holding.
  logic [31:0] exp_id_pc;
  logic [31:0] exp_id_inst;
  logic [31:0] cur_addr;
  logic        dlv;
  logic [31:0] dlv_pc;
  logic [31:0] dlv_inst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs already set; check outputs, advance, update reference.
  task automatic cyc(input string tag, input logic exp_req, input logic exp_sr);
    logic       f;
    logic       r;
    logic       d;
    logic [5:0] s;
    #1;
    chk({tag, ".inst_req"}, {31'b0, inst_req}, {31'b0, exp_req});
    chk({tag, ".stallreq"}, {31'b0, stallreq_o}, {31'b0, exp_sr});
    if (exp_req) chk({tag, ".inst_addr"}, inst_addr, cur_addr);
    chk({tag, ".id_pc"}, id_pc, exp_id_pc);
    chk({tag, ".id_inst"}, id_inst, exp_id_inst);
    f = flush;
    r = rst;
    d = dlv;
    s = stall;
    @(posedge clk);
    if (r || f || (s[1] && !s[2])) begin
      exp_id_pc   = 32'h0;
      exp_id_inst = NOP;
    end else if (s[1]) begin
      exp_id_pc   = exp_id_pc;
      exp_id_inst = exp_id_inst;
    end else if (d) begin
      exp_id_pc   = dlv_pc;
      exp_id_inst = dlv_inst;
    end else begin
      exp_id_pc   = 32'h0;
      exp_id_inst = NOP;
    end
    #1;
  endtask

  // Full fetch: aw idle REQ cycles before addr_ok, dw idle RESP cycles before
  // data_ok, hold cycles of downstream stall in DONE, then hand-over.
  task automatic do_fetch(input string tag, input logic [31:0] pc, input logic [31:0] data,
                          input int aw, input int dw, input int hold);
    pc_i     = pc;
    ce_i     = 1'b1;
    cur_addr = pc;
    cyc({tag, ".idle"}, 1'b0, 1'b1);
    ce_i = 1'b0;
    pc_i = $urandom;
    for (int i = 0; i <= aw; i++) begin
      inst_addr_ok = (i == aw);
      cyc({tag, ".req"}, 1'b1, 1'b1);
    end
    inst_addr_ok = 1'b0;
    for (int j = 0; j <= dw; j++) begin
      inst_data_ok = (j == dw);
      inst_rdata   = (j == dw) ? data : $urandom;
      cyc({tag, ".resp"}, 1'b0, 1'b1);
    end
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    for (int k = 0; k < hold; k++) begin
      ovr_en  = 1'b1;
      ovr_val = 6'b000111;
      cyc({tag, ".hold"}, 1'b0, 1'b0);
    end
    ovr_en   = 1'b0;
    dlv      = 1'b1;
    dlv_pc   = pc;
    dlv_inst = data;
    cyc({tag, ".load"}, 1'b0, 1'b0);
    dlv = 1'b0;
    #1;
    chk({tag, ".out_pc"}, id_pc, pc);
    chk({tag, ".out_inst"}, id_inst, data);
    #0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    pc_i         = 32'h0;
    ce_i         = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    ovr_en       = 1'b0;
    ovr_val      = 6'b0;
    dlv          = 1'b0;
    dlv_pc       = 32'h0;
    dlv_inst     = 32'h0;
    cur_addr     = 32'h0;
    exp_id_pc    = 32'h0;
    exp_id_inst  = NOP;

    // Reset state
    @(posedge clk);
    #1;
    ce_i = 1'b1;
    cyc("reset", 1'b0, 1'b0);
    chk("reset.inst_addr", inst_addr, 32'h0);
    rst  = 1'b0;
    ce_i = 1'b0;
    cyc("post_reset", 1'b0, 1'b0);

    // Zero-wait fetch, downstream-ready: result at the 4th edge
    do_fetch("zero_wait", 32'h0000_0000, 32'h3C01_0001, 0, 0, 0);
    cyc("zw.after", 1'b0, 1'b0);

    // Backpressure on address and data phases
    do_fetch("backpress", 32'h0000_1004, 32'h2402_00FF, 3, 1, 0);

    // Downstream stall while DONE holds the word
    do_fetch("ds_stall", 32'h0000_2008, 32'h8C43_0010, 0, 0, 2);

    // Flush while waiting for data; the late word must be dropped
    pc_i     = 32'h0000_3000;
    ce_i     = 1'b1;
    cur_addr = 32'h0000_3000;
    cyc("frsp.idle", 1'b0, 1'b1);
    ce_i         = 1'b0;
    inst_addr_ok = 1'b1;
    cyc("frsp.req", 1'b1, 1'b1);
    inst_addr_ok = 1'b0;
    flush        = 1'b1;
    cyc("frsp.flush", 1'b0, 1'b1);
    flush = 1'b0;
    cyc("frsp.wait", 1'b0, 1'b1);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    cyc("frsp.drop", 1'b0, 1'b1);
    inst_data_ok = 1'b0;
    cyc("frsp.idle2", 1'b0, 1'b0);
    chk("frsp.no_beef", id_inst, NOP);
    do_fetch("frsp.next", 32'h0000_4000, 32'h0000_0025, 0, 0, 0);

    // Flush during REQ: request held until accepted, response drained
    pc_i     = 32'h0000_5000;
    ce_i     = 1'b1;
    cur_addr = 32'h0000_5000;
    cyc("freq.idle", 1'b0, 1'b1);
    ce_i  = 1'b0;
    flush = 1'b1;
    cyc("freq.flush", 1'b1, 1'b1);
    flush = 1'b0;
    cyc("freq.hold", 1'b1, 1'b1);
    inst_addr_ok = 1'b1;
    cyc("freq.accept", 1'b1, 1'b1);
    inst_addr_ok = 1'b0;
    cyc("freq.disc", 1'b0, 1'b1);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h1234_5678;
    cyc("freq.drop", 1'b0, 1'b1);
    inst_data_ok = 1'b0;
    cyc("freq.idle2", 1'b0, 1'b0);
    chk("freq.no_update", id_inst, NOP);

    // Flush coinciding with data: straight back to idle
    pc_i     = 32'h0000_6000;
    ce_i     = 1'b1;
    cur_addr = 32'h0000_6000;
    cyc("fsim.idle", 1'b0, 1'b1);
    ce_i         = 1'b0;
    inst_addr_ok = 1'b1;
    cyc("fsim.req", 1'b1, 1'b1);
    inst_addr_ok = 1'b0;
    flush        = 1'b1;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hCAFE_F00D;
    cyc("fsim.flush", 1'b0, 1'b1);
    flush        = 1'b0;
    inst_data_ok = 1'b0;
    cyc("fsim.idle2", 1'b0, 1'b0);

    // Flush while DONE: buffered word discarded
    pc_i     = 32'h0000_7000;
    ce_i     = 1'b1;
    cur_addr = 32'h0000_7000;
    cyc("fdone.idle", 1'b0, 1'b1);
    ce_i         = 1'b0;
    inst_addr_ok = 1'b1;
    cyc("fdone.req", 1'b1, 1'b1);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hABCD_0001;
    cyc("fdone.resp", 1'b0, 1'b1);
    inst_data_ok = 1'b0;
    ovr_en       = 1'b1;
    ovr_val      = 6'b000111;
    flush        = 1'b1;
    cyc("fdone.flush", 1'b0, 1'b0);
    ovr_en = 1'b0;
    flush  = 1'b0;
    cyc("fdone.idle2", 1'b0, 1'b0);
    cyc("fdone.idle3", 1'b0, 1'b0);

    // Reset in the middle of a response wait
    pc_i     = 32'h0000_8000;
    ce_i     = 1'b1;
    cur_addr = 32'h0000_8000;
    cyc("rstm.idle", 1'b0, 1'b1);
    ce_i         = 1'b0;
    inst_addr_ok = 1'b1;
    cyc("rstm.req", 1'b1, 1'b1);
    inst_addr_ok = 1'b0;
    cyc("rstm.resp", 1'b0, 1'b1);
    rst = 1'b1;
    cyc("rstm.rst", 1'b0, 1'b0);
    rst = 1'b0;
    chk("rstm.inst_addr", inst_addr, 32'h0);
    chk("rstm.id_pc", id_pc, 32'h0);
    chk("rstm.id_inst", id_inst, NOP);
    cyc("rstm.idle2", 1'b0, 1'b0);
    do_fetch("rstm.next", 32'h0000_9000, 32'h0000_000C, 1, 0, 1);

    // Randomized fetches with random latencies and downstream holds
    for (int t = 0; t < 16; t++) begin
      do_fetch("rnd", $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) cyc("rnd.gap", 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
